fb_uart_dump: RTL and testbench

// - Reads the 8-bit colour-index framebuffer back out and streams it over UART 8N1.
// - This gives host-side capture of a rendered frame for regression against a software model.
// - Sits beside the renderer on clk_sys: the renderer writes the framebuffer, this block reads it.
// - Drives its own read port of the framebuffer BRAM, which has 1-cycle registered read latency.

---
 rtl/fb_dump_pkg.sv | 19 +
 rtl/fb_uart_dump_if.sv | 16 +
 rtl/fb_uart_dump_uart_tx.sv | 66 ++++++
 rtl/fb_uart_dump.sv | 138 +++++++++++++
 tb/tb_fb_uart_dump.sv | 354 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fb_dump_pkg.sv
// Shared definitions for the framebuffer UART dump block.
// Contents: sync header bytes sent ahead of every dump and the FSM state enum.
package fb_dump_pkg;

  localparam logic [7:0] SYNC0 = 8'hA5;
  localparam logic [7:0] SYNC1 = 8'h5A;

  typedef enum logic [2:0] {
    IDLE,
    HDR0,
    HDR1,
    FETCH,
    LOAD,
    SEND,
    CSUM,
    FIN
  } state_t;

endpackage

// File: rtl/fb_uart_dump_if.sv
// Framebuffer read port bundle.
// Ports:
//   fb_addr  read address, driven by the reader (master)
//   fb_data  read data, returned by the memory (slave) one cycle after fb_addr
interface fb_uart_dump_if #(
  parameter int ADDRW = 16,
  parameter int DATAW = 8
);

  logic [ADDRW-1:0] fb_addr;
  logic [DATAW-1:0] fb_data;

  modport master (output fb_addr, input fb_data);
  modport slave  (input fb_addr, output fb_data);

endinterface

// File: rtl/fb_uart_dump_uart_tx.sv
// UART 8N1 serialiser, also reused for debug output.
// Ports:
//   clk, rst  system clock, synchronous active-high reset
//   data      byte to send, sampled when valid && ready
//   valid     byte offered
//   ready     high only while the serialiser is idle
//   tx        serial line, idles high
module uart_tx #(
  parameter int UART_DIV = 87
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data,
  input  logic       valid,
  output logic       ready,
  output logic       tx
);

  localparam int CNT_W = $clog2(UART_DIV);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(UART_DIV - 1);

  logic             active;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       bit_idx;
  logic [7:0]       shreg;

  assign ready = ~active;

  // bit_idx: 0 = start, 1..8 = data LSB first, 9 = stop.
  always_ff @(posedge clk) begin
    if (rst) begin
      active  <= 1'b0;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      tx      <= 1'b1;
    end else if (!active) begin
      if (valid) begin
        active  <= 1'b1;
        cnt     <= '0;
        bit_idx <= '0;
        shreg   <= data;
        tx      <= 1'b0;
      end
    end else if (cnt == CNT_MAX) begin
      cnt <= '0;
      if (bit_idx == 4'd9) begin
        // Going idle here lets the next byte start on the following cycle,
        // so inter-byte gaps stay at a single idle-high cycle.
        active <= 1'b0;
        tx     <= 1'b1;
      end else begin
        bit_idx <= bit_idx + 4'd1;
        if (bit_idx == 4'd8) begin
          tx <= 1'b1;
        end else begin
          tx    <= shreg[0];
          shreg <= {1'b0, shreg[7:1]};
        end
      end
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/fb_uart_dump.sv
// Framebuffer dump: reads the 8-bit colour-index framebuffer and streams it
// over UART as A5, 5A, FB_PIXELS pixel bytes, then the XOR of the pixel bytes.
// Ports:
//   clk, rst  system clock, synchronous active-high reset
//   start     1-cycle pulse to begin a dump; ignored while busy or while done pulses
//   fb        framebuffer read port (master side), 1-cycle read latency
//   uart_tx   serial output, idles high
//   busy      high from the cycle after an accepted start until done
//   done      1-cycle pulse once the checksum stop bit has finished
// The BRAM read-address mux against the linebuffer (selected by busy) sits
// in the integrating level, not here.
//
// state | meaning
// IDLE  | waiting for start
// HDR0  | offering SYNC0
// HDR1  | offering SYNC1
// FETCH | fb_addr stable, waiting out BRAM read latency
// LOAD  | capture fb_data, fold into checksum
// SEND  | offering pixel byte
// CSUM  | offering checksum byte
// FIN   | waiting for final stop bit, then pulse done
module fb_uart_dump
  import fb_dump_pkg::*;
#(
  parameter int FB_PIXELS = 57600,
  parameter int ADDRW     = 16,
  parameter int DATAW     = 8,
  parameter int UART_DIV  = 87
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  fb_uart_dump_if.master        fb,
  output logic                  uart_tx,
  output logic                  busy,
  output logic                  done
);

  localparam logic [ADDRW-1:0] LAST_ADDR = ADDRW'(FB_PIXELS - 1);

  state_t           state;
  logic [ADDRW-1:0] addr;
  logic [DATAW-1:0] pix;
  logic [DATAW-1:0] checksum;
  logic             tx_valid;
  logic             tx_ready;
  logic [7:0]       tx_data;
  logic             tx_accept;

  assign fb.fb_addr = addr;
  assign tx_accept  = tx_valid && tx_ready;

  always_comb begin
    tx_valid = 1'b0;
    tx_data  = SYNC0;
    case (state)
      HDR0: begin
        tx_valid = 1'b1;
        tx_data  = SYNC0;
      end
      HDR1: begin
        tx_valid = 1'b1;
        tx_data  = SYNC1;
      end
      SEND: begin
        tx_valid = 1'b1;
        tx_data  = pix;
      end
      CSUM: begin
        tx_valid = 1'b1;
        tx_data  = checksum;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      addr     <= '0;
      pix      <= '0;
      checksum <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          // done is still high in the first IDLE cycle; a start there belongs
          // to the finished dump and must not launch a new one.
          if (start && !done) begin
            state    <= HDR0;
            busy     <= 1'b1;
            checksum <= '0;
            addr     <= '0;
          end
        end
        HDR0: if (tx_accept) state <= HDR1;
        HDR1: if (tx_accept) state <= FETCH;
        FETCH: state <= LOAD;
        LOAD: begin
          pix      <= fb.fb_data;
          checksum <= checksum ^ fb.fb_data;
          state    <= SEND;
        end
        SEND: begin
          if (tx_accept) begin
            if (addr == LAST_ADDR) begin
              state <= CSUM;
            end else begin
              addr  <= addr + ADDRW'(1);
              state <= FETCH;
            end
          end
        end
        CSUM: if (tx_accept) state <= FIN;
        FIN: begin
          if (tx_ready) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  uart_tx #(.UART_DIV(UART_DIV)) u_tx (
    .clk   (clk),
    .rst   (rst),
    .data  (tx_data),
    .valid (tx_valid),
    .ready (tx_ready),
    .tx    (uart_tx)
  );

endmodule

// File: tb/tb_fb_uart_dump.sv
// Self-checking bench for fb_uart_dump with a small framebuffer and fast UART.
module tb_fb_uart_dump;
  import fb_dump_pkg::*;

  localparam int NPIX    = 4;
  localparam int AW      = 2;
  localparam int DIV     = 4;
  localparam int NBYTES  = NPIX + 3;
  localparam int TIMEOUT = 3000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic uart_tx, busy, done;

  fb_uart_dump_if #(.ADDRW(AW), .DATAW(8)) fb_bus ();

  fb_uart_dump #(.FB_PIXELS(NPIX), .ADDRW(AW), .DATAW(8), .UART_DIV(DIV)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .fb      (fb_bus),
    .uart_tx (uart_tx),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [NPIX];
  always @(posedge clk) fb_bus.fb_data <= mem[fb_bus.fb_addr];

  int n_pass = 0;
  int n_total = 0;

  // Line monitor / UART decoder, sampling on the falling edge.
  logic [7:0] rx_q[$];
  logic [7:0] exp_q[$];
  int addr_q[$];
  int edges, glitch_err, frame_err, done_cnt, busy_done_err, gap_max;
  int cyc = 0;
  int last_end = 0;
  bit dec_active = 0;
  int dec_pos = 0;
  logic [9:0] dec_bits;
  logic prev_tx = 1'b1;
  logic prev_busy = 1'b0;
  int prev_addr = 0;

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      dec_active = 0;
      prev_tx = 1'b1;
      prev_busy = 1'b0;
    end else begin
      if (uart_tx !== prev_tx) edges++;
      if (done === 1'b1) done_cnt++;
      if (prev_busy && busy !== 1'b1 && done !== 1'b1) busy_done_err++;
      if (busy === 1'b1 && (!prev_busy || int'(fb_bus.fb_addr) != prev_addr))
        addr_q.push_back(int'(fb_bus.fb_addr));
      if (!dec_active && uart_tx === 1'b0) begin
        dec_active = 1;
        dec_pos = 0;
        dec_bits = '1;
        if (rx_q.size() > 0 && (cyc - last_end - 1) > gap_max) gap_max = cyc - last_end - 1;
      end
      if (dec_active) begin
        if (dec_pos % DIV == 0) dec_bits[dec_pos / DIV] = uart_tx;
        else if (uart_tx !== dec_bits[dec_pos / DIV]) glitch_err++;
        if (dec_pos == 10 * DIV - 1) begin
          if (dec_bits[0] !== 1'b0 || dec_bits[9] !== 1'b1) frame_err++;
          rx_q.push_back(dec_bits[8:1]);
          dec_active = 0;
          last_end = cyc;
        end else begin
          dec_pos++;
        end
      end
      prev_tx = uart_tx;
      prev_busy = busy;
      prev_addr = int'(fb_bus.fb_addr);
    end
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  // Reference model: the frame a dump of mem must produce.
  function automatic void model_frame();
    logic [7:0] cs;
    cs = 8'h00;
    exp_q.delete();
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h5A);
    for (int i = 0; i < NPIX; i++) begin
      exp_q.push_back(mem[i]);
      cs ^= mem[i];
    end
    exp_q.push_back(cs);
  endfunction

  // Number of line transitions for exp_q sent as 8N1 from an idle-high line.
  function automatic int model_edges();
    int e;
    logic p;
    logic [9:0] w;
    e = 0;
    p = 1'b1;
    foreach (exp_q[k]) begin
      w = {1'b1, exp_q[k], 1'b0};
      for (int b = 0; b < 10; b++) begin
        if (w[b] != p) e++;
        p = w[b];
      end
    end
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_mon();
    rx_q.delete();
    addr_q.delete();
    edges = 0;
    glitch_err = 0;
    frame_err = 0;
    done_cnt = 0;
    busy_done_err = 0;
    gap_max = 0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(output bit ok);
    ok = 0;
    for (int i = 0; i < TIMEOUT; i++) begin
      tick();
      if (done === 1'b1) begin
        ok = 1;
        break;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic fill_random();
    for (int i = 0; i < NPIX; i++) mem[i] = 8'($urandom);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle(3);
    rst = 1'b0;
    n_total++; if (uart_tx !== 1'b1) $display("FAIL reset_uart_tx: got %b want 1", uart_tx); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
    n_total++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else n_pass++;
    n_total++; if (fb_bus.fb_addr !== 2'd0) $display("FAIL reset_fb_addr: got %0d want 0", fb_bus.fb_addr); else n_pass++;
    clear_mon();
    idle(100);
    n_total++; if (edges != 0) $display("FAIL reset_quiet_line: got %0d edges want 0", edges); else n_pass++;
  endtask

  task automatic test_basic();
    bit ok;
    mem[0] = 8'h01; mem[1] = 8'h02; mem[2] = 8'h04; mem[3] = 8'h80;
    model_frame();
    clear_mon();
    pulse_start();
    n_total++; if (busy !== 1'b1) $display("FAIL basic_busy_rise: got %b want 1", busy); else n_pass++;
    wait_done(ok);
    n_total++; if (!ok) $display("FAIL basic_done_timeout: got no done want done"); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL basic_busy_with_done: got %b want 0", busy); else n_pass++;
    idle(20);
    n_total++; if (rx_q.size() != NBYTES) $display("FAIL basic_byte_count: got %0d want %0d", rx_q.size(), NBYTES); else n_pass++;
    for (int i = 0; i < NBYTES && i < rx_q.size(); i++) begin
      n_total++; if (rx_q[i] !== exp_q[i]) $display("FAIL basic_byte%0d: got %h want %h", i, rx_q[i], exp_q[i]); else n_pass++;
    end
    n_total++; if (exp_q[NBYTES-1] !== 8'h87) $display("FAIL basic_model_csum: got %h want 87", exp_q[NBYTES-1]); else n_pass++;
    n_total++; if (glitch_err != 0) $display("FAIL basic_bit_width: got %0d glitches want 0", glitch_err); else n_pass++;
    n_total++; if (frame_err != 0) $display("FAIL basic_framing: got %0d errors want 0", frame_err); else n_pass++;
    n_total++; if (gap_max > 3) $display("FAIL basic_gap: got %0d cycles want <=3", gap_max); else n_pass++;
    n_total++; if (done_cnt != 1) $display("FAIL basic_done_count: got %0d want 1", done_cnt); else n_pass++;
    n_total++; if (busy_done_err != 0) $display("FAIL basic_busy_fall: got %0d misaligned want 0", busy_done_err); else n_pass++;
    n_total++; if (edges != model_edges()) $display("FAIL basic_edges: got %0d want %0d", edges, model_edges()); else n_pass++;
    n_total++; if (addr_q.size() != NPIX) $display("FAIL basic_addr_count: got %0d want %0d", addr_q.size(), NPIX); else n_pass++;
    for (int i = 0; i < NPIX && i < addr_q.size(); i++) begin
      n_total++; if (addr_q[i] != i) $display("FAIL basic_addr%0d: got %0d want %0d", i, addr_q[i], i); else n_pass++;
    end
  endtask

  task automatic test_ignore_start();
    bit ok;
    int cnt;
    fill_random();
    model_frame();
    clear_mon();
    pulse_start();
    ok = 0;
    cnt = 0;
    for (int i = 0; i < TIMEOUT && !ok; i++) begin
      tick();
      cnt++;
      if (done === 1'b1) ok = 1;
      start = (cnt % 10 == 0) || (done === 1'b1);
    end
    tick();
    start = 1'b0;
    n_total++; if (!ok) $display("FAIL ignore_done_timeout: got no done want done"); else n_pass++;
    idle(100);
    n_total++; if (rx_q.size() != NBYTES) $display("FAIL ignore_byte_count: got %0d want %0d", rx_q.size(), NBYTES); else n_pass++;
    n_total++; if (done_cnt != 1) $display("FAIL ignore_done_count: got %0d want 1", done_cnt); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL ignore_busy_after: got %b want 0", busy); else n_pass++;
    for (int i = 0; i < NBYTES && i < rx_q.size(); i++) begin
      n_total++; if (rx_q[i] !== exp_q[i]) $display("FAIL ignore_byte%0d: got %h want %h", i, rx_q[i], exp_q[i]); else n_pass++;
    end
  endtask

  task automatic test_checksum();
    bit ok;
    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 0; i < NPIX; i++) mem[i] = (pass == 0) ? 8'hFF : 8'h00;
      model_frame();
      clear_mon();
      pulse_start();
      wait_done(ok);
      n_total++; if (!ok) $display("FAIL csum%0d_done_timeout: got no done want done", pass); else n_pass++;
      idle(20);
      n_total++; if (rx_q.size() != NBYTES) $display("FAIL csum%0d_byte_count: got %0d want %0d", pass, rx_q.size(), NBYTES); else n_pass++;
      for (int i = 0; i < NBYTES && i < rx_q.size(); i++) begin
        n_total++; if (rx_q[i] !== exp_q[i]) $display("FAIL csum%0d_byte%0d: got %h want %h", pass, i, rx_q[i], exp_q[i]); else n_pass++;
      end
      if (rx_q.size() == NBYTES) begin
        n_total++; if (rx_q[NBYTES-1] !== 8'h00) $display("FAIL csum%0d_value: got %h want 00", pass, rx_q[NBYTES-1]); else n_pass++;
      end
      n_total++; if (edges != model_edges()) $display("FAIL csum%0d_edges: got %0d want %0d", pass, edges, model_edges()); else n_pass++;
    end
  endtask

  task automatic test_abort();
    bit ok;
    fill_random();
    mem[0] = mem[0] & 8'hFB;  // bit 3 of the third byte (data bit 2) is low
    clear_mon();
    pulse_start();
    ok = 0;
    for (int i = 0; i < TIMEOUT; i++) begin
      tick();
      if (rx_q.size() == 2 && dec_active && dec_pos >= 3 * DIV + 1 && dec_pos < 4 * DIV - 1) begin
        ok = 1;
        break;
      end
    end
    n_total++; if (!ok) $display("FAIL abort_reach_bit3: got timeout want third byte bit 3"); else n_pass++;
    n_total++; if (uart_tx !== 1'b0) $display("FAIL abort_line_before: got %b want 0", uart_tx); else n_pass++;
    rst = 1'b1;
    tick();
    n_total++; if (uart_tx !== 1'b1) $display("FAIL abort_uart_tx: got %b want 1", uart_tx); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL abort_busy: got %b want 0", busy); else n_pass++;
    tick();
    rst = 1'b0;
    idle(5);
    fill_random();
    model_frame();
    clear_mon();
    pulse_start();
    wait_done(ok);
    n_total++; if (!ok) $display("FAIL abort_redo_timeout: got no done want done"); else n_pass++;
    idle(20);
    n_total++; if (rx_q.size() != NBYTES) $display("FAIL abort_byte_count: got %0d want %0d", rx_q.size(), NBYTES); else n_pass++;
    for (int i = 0; i < NBYTES && i < rx_q.size(); i++) begin
      n_total++; if (rx_q[i] !== exp_q[i]) $display("FAIL abort_byte%0d: got %h want %h", i, rx_q[i], exp_q[i]); else n_pass++;
    end
    n_total++; if (addr_q.size() == 0 || addr_q[0] != 0) $display("FAIL abort_first_addr: got %0d entries want start at 0", addr_q.size()); else n_pass++;
  endtask

  task automatic test_back_to_back();
    bit ok;
    logic [7:0] first_q[$];
    fill_random();
    model_frame();
    clear_mon();
    pulse_start();
    wait_done(ok);
    n_total++; if (!ok) $display("FAIL b2b_first_timeout: got no done want done"); else n_pass++;
    first_q = rx_q;
    tick();
    clear_mon();
    pulse_start();
    n_total++; if (busy !== 1'b1) $display("FAIL b2b_restart_busy: got %b want 1", busy); else n_pass++;
    wait_done(ok);
    n_total++; if (!ok) $display("FAIL b2b_second_timeout: got no done want done"); else n_pass++;
    idle(20);
    n_total++; if (first_q.size() != NBYTES) $display("FAIL b2b_first_count: got %0d want %0d", first_q.size(), NBYTES); else n_pass++;
    n_total++; if (rx_q.size() != NBYTES) $display("FAIL b2b_second_count: got %0d want %0d", rx_q.size(), NBYTES); else n_pass++;
    for (int i = 0; i < NBYTES && i < first_q.size(); i++) begin
      n_total++; if (first_q[i] !== exp_q[i]) $display("FAIL b2b_first_byte%0d: got %h want %h", i, first_q[i], exp_q[i]); else n_pass++;
    end
    for (int i = 0; i < NBYTES && i < rx_q.size(); i++) begin
      n_total++; if (rx_q[i] !== exp_q[i]) $display("FAIL b2b_second_byte%0d: got %h want %h", i, rx_q[i], exp_q[i]); else n_pass++;
    end
    n_total++; if (addr_q.size() != NPIX) $display("FAIL b2b_addr_count: got %0d want %0d", addr_q.size(), NPIX); else n_pass++;
    for (int i = 0; i < NPIX && i < addr_q.size(); i++) begin
      n_total++; if (addr_q[i] != i) $display("FAIL b2b_addr%0d: got %0d want %0d", i, addr_q[i], i); else n_pass++;
    end
  endtask

  task automatic test_random();
    bit ok;
    for (int r = 0; r < 4; r++) begin
      fill_random();
      model_frame();
      idle($urandom_range(0, 20));
      clear_mon();
      pulse_start();
      wait_done(ok);
      n_total++; if (!ok) $display("FAIL rand%0d_timeout: got no done want done", r); else n_pass++;
      idle(20);
      n_total++; if (rx_q.size() != NBYTES) $display("FAIL rand%0d_byte_count: got %0d want %0d", r, rx_q.size(), NBYTES); else n_pass++;
      for (int i = 0; i < NBYTES && i < rx_q.size(); i++) begin
        n_total++; if (rx_q[i] !== exp_q[i]) $display("FAIL rand%0d_byte%0d: got %h want %h", r, i, rx_q[i], exp_q[i]); else n_pass++;
      end
      n_total++; if (glitch_err != 0 || frame_err != 0) $display("FAIL rand%0d_line: got %0d/%0d errors want 0/0", r, glitch_err, frame_err); else n_pass++;
      n_total++; if (gap_max > 3) $display("FAIL rand%0d_gap: got %0d want <=3", r, gap_max); else n_pass++;
    end
  endtask

  initial begin
    for (int i = 0; i < NPIX; i++) mem[i] = 8'h00;
    test_reset();
    test_basic();
    test_ignore_start();
    test_checksum();
    test_abort();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
